uart_parity_gen: RTL and testbench
==================================

Name: uart_parity_gen

Overview:
Parametrised parity generator for the UART TX path and successor to the fixed-width even/odd parity calculator.
- Supports runtime-selectable frame length (MIN_WIDTH..MAX_WIDTH bits) and five parity modes: none, even, odd, mark, space.
- Uses a valid/ready handshake to accept a data word, then computes parity bit-serially (one bit per clock).
- Holds the result stable for the TX FSM until the frame completes.

Parameters:
- MAX_WIDTH, 8, widest data word in bits.
- MIN_WIDTH, 5, narrowest legal data word in bits.
- LEN_W, 4, width of data_len; must be at least clog2(MAX_WIDTH+1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  MAX_WIDTH  parallel data word; bit 0 is transmitted first.
- data_len  input  LEN_W  number of valid data bits; sampled on accept.
- par_mode  input  3  000 none, 001 even, 010 odd, 011 mark, 100 space; 101–111 are treated as none. Sampled on accept.
- data_valid  input  1  upstream offers a word.
- data_ready  output  1  block can accept a word.
- frame_done  input  1  one-cycle pulse from the TX FSM: parity has been consumed.
- parity_bit  output  1  computed parity bit.
- parity_valid  output  1  parity_bit is valid and stable.
- parity_en  output  1  latched mode is not none; TX inserts a parity slot only when this is 1.

Behaviour:
- Clock and reset:
  - Single clock (clk); reset is synchronous and active-high (rst).
  - While rst=1, every output is 0, including data_ready.
  - On the first edge after rst falls: state is IDLE, data_ready=1, all other outputs 0.
- States: IDLE, CALC, HOLD.
- Output decode:
  - data_ready = (state==IDLE) && !rst; combinational from state.
  - parity_valid = (state==HOLD).
- Accept:
  - An accept occurs on an edge where data_valid && data_ready.
  - On accept: latch data_in, the effective length N, and par_mode. Clear the accumulator and the bit index. Go to CALC.
- Effective length N:
  - N = data_len when MIN_WIDTH <= data_len <= MAX_WIDTH.
  - Otherwise N = MAX_WIDTH (clamp; no error is flagged).
- CALC:
  - Each edge XORs latched bit[idx] into the accumulator and increments idx.
  - After the edge that processes bit N-1, go to HOLD and register the outputs.
  - Latency: parity_valid rises exactly N edges after the accept edge (8 cycles for an 8-bit word).
- Result encoding, registered on entry to HOLD:
  - even: parity_bit = XOR of bits.
  - odd: parity_bit = ~XOR.
  - mark: parity_bit = 1.
  - space: parity_bit = 0.
  - none: parity_bit = 0 and parity_en = 0.
  - parity_en = 1 for every mode except none.
  - Mark, space and none still spend N cycles in CALC, so latency does not depend on mode.
- HOLD:
  - parity_bit and parity_en stay stable.
  - frame_done=1 → IDLE; parity_valid drops and data_ready rises on the same edge.
  - parity_bit and parity_en keep their last values in IDLE and change only on the next HOLD entry.
- Ignored events:
  - frame_done in IDLE or CALC is ignored.
  - data_valid in CALC or HOLD is ignored; the upstream holds the word until data_ready.
  - frame_done together with data_valid in HOLD → IDLE only; the word is accepted on the following edge.
- Back-to-back frames: accept-to-accept minimum is N+2 cycles (N in CALC, 1 in HOLD with frame_done, 1 in IDLE).
- Reset mid-CALC or mid-HOLD: abandon immediately, no partial result is exposed, all outputs 0.
- Input isolation: data_in, data_len and par_mode may change freely after accept without affecting the in-flight result.

Optional Feature:
- Macro: UART_PARITY_CHECK_EN.
- When defined, add three ports:
  - chk_bit  input  1  received parity bit to compare.
  - chk_strobe  input  1  compare request.
  - parity_err  output  1  sticky mismatch flag.
- Compare rule: in HOLD with parity_en=1, a chk_strobe edge sets parity_err if chk_bit != parity_bit.
- parity_err is cleared by rst or by the next accept; chk_strobe outside HOLD, or with parity_en=0, is ignored.
- When undefined: none of these ports exist, and behaviour is otherwise identical.

Decomposition:
- Package uart_parity_pkg:
  - parity mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE);
  - state encoding (ST_IDLE, ST_CALC, ST_HOLD);
  - mode width constant 3.
- No sub-module: the bit counter, accumulator and FSM are small enough to stay in one module.

Test Plan:
- Even parity: data 8'hA5, len 8, mode even → parity_valid 8 cycles after accept, parity_bit=0, parity_en=1; same word in odd mode → parity_bit=1.
- Short frame: data 8'hFF, len 5, even → only bits [4:0] are counted, parity_bit=1, latency 5 cycles. Out-of-range length: data 8'h07, len 3 → clamped to 8, parity_bit=1.
- Fixed-value modes: mark → 1, space → 0, mode 3'b110 → parity_en=0 and parity_bit=0; all three with 8-cycle latency.
- Handshake: data_valid held high through CALC/HOLD gives exactly one accept; frame_done in HOLD gives data_ready=1 the next cycle; two back-to-back words are 10 cycles apart at len 8.
- Reset: rst for 1 cycle in the middle of CALC → all outputs 0, data_ready=1 after release, parity_valid never pulses for the aborted word.
- With UART_PARITY_CHECK_EN: 8'hA5 even, chk_bit=1 strobed in HOLD → parity_err=1, cleared on next accept; chk_bit=0 → parity_err stays 0.

Source files
------------

// File: rtl/uart_parity_pkg.sv
// -----------------------------------------------------------------------------
// uart_parity_pkg
//   Shared types and constants for the UART TX parity generator.
//   - par_mode_t : parity mode encodings as presented on the par_mode port
//   - state_t    : generator FSM states
//   - MODE_W     : width of the par_mode port
//   - decode_mode: maps a raw par_mode value onto par_mode_t (reserved
//                  codes 101..111 collapse to PAR_NONE)
// -----------------------------------------------------------------------------
package uart_parity_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        PAR_NONE  = 3'b000,
        PAR_EVEN  = 3'b001,
        PAR_ODD   = 3'b010,
        PAR_MARK  = 3'b011,
        PAR_SPACE = 3'b100
    } par_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_HOLD
    } state_t;

    function automatic par_mode_t decode_mode(input logic [MODE_W-1:0] mode);
        case (mode)
            3'b001:  return PAR_EVEN;
            3'b010:  return PAR_ODD;
            3'b011:  return PAR_MARK;
            3'b100:  return PAR_SPACE;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// -----------------------------------------------------------------------------
// uart_parity_gen
//   Bit-serial parity generator for the UART TX path. A data word is accepted
//   over a valid/ready handshake, its parity is accumulated one bit per clock
//   (bit 0 first), and the result is held stable until the TX FSM reports
//   the frame complete.
//
// Parameters
//   MAX_WIDTH  widest data word (bits)
//   MIN_WIDTH  narrowest legal data word (bits); out-of-range lengths clamp
//              to MAX_WIDTH
//   LEN_W      width of data_len, at least clog2(MAX_WIDTH+1)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   data_in       parallel data word, bit 0 transmitted first
//   data_len      number of valid data bits, sampled on accept
//   par_mode      000 none, 001 even, 010 odd, 011 mark, 100 space
//                 (others = none), sampled on accept
//   data_valid    upstream offers a word
//   data_ready    block can accept a word
//   frame_done    one-cycle pulse from TX FSM: parity consumed
//   parity_bit    computed parity bit
//   parity_valid  parity_bit is valid and stable
//   parity_en     latched mode is not none (TX inserts a parity slot)
//
// Optional feature (macro UART_PARITY_CHECK_EN)
//   chk_bit       received parity bit to compare
//   chk_strobe    compare request, honoured in HOLD with parity_en=1
//   parity_err    sticky mismatch flag, cleared by rst or the next accept
// -----------------------------------------------------------------------------
module uart_parity_gen
    import uart_parity_pkg::*;
#(
    parameter int MAX_WIDTH = 8,
    parameter int MIN_WIDTH = 5,
    parameter int LEN_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAX_WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0]     data_len,
    input  logic [MODE_W-1:0]    par_mode,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic                 frame_done,
`ifdef UART_PARITY_CHECK_EN
    input  logic                 chk_bit,
    input  logic                 chk_strobe,
    output logic                 parity_err,
`endif
    output logic                 parity_bit,
    output logic                 parity_valid,
    output logic                 parity_en
);

    state_t                 state_q;
    par_mode_t              mode_q;
    logic [MAX_WIDTH-1:0]   shift_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       idx_q;
    logic                   acc_q;
    logic                   parity_q;
    logic                   par_en_q;

    logic                   acc_next;
    logic                   last_bit;
    logic [LEN_W-1:0]       len_eff;

    // The word is consumed from a shift register, so the next bit is always
    // shift_q[0] and no variable-index mux is needed.
    assign acc_next = acc_q ^ shift_q[0];
    assign last_bit = (idx_q == len_q - LEN_W'(1));

    assign len_eff = ((data_len >= LEN_W'(MIN_WIDTH)) && (data_len <= LEN_W'(MAX_WIDTH)))
                   ? data_len : LEN_W'(MAX_WIDTH);

    // Outputs are forced low for the whole reset cycle, not only after the
    // edge that clears the registers, so a partial result is never exposed.
    assign data_ready   = (state_q == ST_IDLE) && !rst;
    assign parity_valid = (state_q == ST_HOLD) && !rst;
    assign parity_bit   = parity_q && !rst;
    assign parity_en    = par_en_q && !rst;

`ifdef UART_PARITY_CHECK_EN
    logic err_q;
    assign parity_err = err_q && !rst;
`endif

    // NOTE: every register here is assigned with <= so all of them update
    // together from pre-edge values; blocking assignments would make the
    // CALC step depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= PAR_NONE;
            shift_q  <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            acc_q    <= 1'b0;
            parity_q <= 1'b0;
            par_en_q <= 1'b0;
`ifdef UART_PARITY_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_valid) begin
                        shift_q <= data_in;
                        len_q   <= len_eff;
                        mode_q  <= decode_mode(par_mode);
                        acc_q   <= 1'b0;
                        idx_q   <= '0;
`ifdef UART_PARITY_CHECK_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    acc_q   <= acc_next;
                    shift_q <= shift_q >> 1;
                    idx_q   <= idx_q + LEN_W'(1);
                    // Fixed-value modes still walk all N bits so latency is
                    // independent of mode.
                    if (last_bit) begin
                        case (mode_q)
                            PAR_EVEN: parity_q <= acc_next;
                            PAR_ODD:  parity_q <= ~acc_next;
                            PAR_MARK: parity_q <= 1'b1;
                            default:  parity_q <= 1'b0;
                        endcase
                        par_en_q <= (mode_q != PAR_NONE);
                        state_q  <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
`ifdef UART_PARITY_CHECK_EN
                    if (chk_strobe && par_en_q && (chk_bit != parity_q)) begin
                        err_q <= 1'b1;
                    end
`endif
                    // A word offered alongside frame_done is taken on the
                    // following edge, from IDLE.
                    if (frame_done) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_parity_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_parity_gen
//   Self-checking bench for uart_parity_gen. Expected parity/enable/latency
//   come from a behavioural model, pushed to a scoreboard queue when a word
//   is offered and popped when parity_valid rises.
//   Build with +define+UART_PARITY_CHECK_EN to cover the parity checker.
// -----------------------------------------------------------------------------
module tb_uart_parity_gen;

    localparam int MAX_WIDTH = 8;
    localparam int MIN_WIDTH = 5;
    localparam int LEN_W     = 4;
    localparam int BOUND     = 40;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [MAX_WIDTH-1:0] data_in = '0;
    logic [LEN_W-1:0]     data_len = '0;
    logic [2:0]           par_mode = '0;
    logic                 data_valid = 1'b0;
    logic                 frame_done = 1'b0;
    logic                 data_ready;
    logic                 parity_bit;
    logic                 parity_valid;
    logic                 parity_en;
`ifdef UART_PARITY_CHECK_EN
    logic                 chk_bit = 1'b0;
    logic                 chk_strobe = 1'b0;
    logic                 parity_err;
`endif

    typedef struct {
        logic pbit;
        logic pen;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   acc_times[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    uart_parity_gen #(
        .MAX_WIDTH(MAX_WIDTH),
        .MIN_WIDTH(MIN_WIDTH),
        .LEN_W    (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_len    (data_len),
        .par_mode    (par_mode),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_done  (frame_done),
`ifdef UART_PARITY_CHECK_EN
        .chk_bit     (chk_bit),
        .chk_strobe  (chk_strobe),
        .parity_err  (parity_err),
`endif
        .parity_bit  (parity_bit),
        .parity_valid(parity_valid),
        .parity_en   (parity_en)
    );

    always #5 clk = ~clk;

    // Accept monitor: logs the cycle number of every handshake edge.
    always @(posedge clk) begin
        if (!rst && data_valid && data_ready) acc_times.push_back(cyc);
        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [7:0] d, input logic [3:0] len,
                                   input logic [2:0] mode);
        exp_t e;
        int   n;
        logic x;
        n = (len >= MIN_WIDTH && len <= MAX_WIDTH) ? int'(len) : MAX_WIDTH;
        x = 1'b0;
        for (int i = 0; i < n; i++) x = x ^ d[i];
        e.lat = n;
        case (mode)
            3'b001:  begin e.pbit = x;    e.pen = 1'b1; end
            3'b010:  begin e.pbit = ~x;   e.pen = 1'b1; end
            3'b011:  begin e.pbit = 1'b1; e.pen = 1'b1; end
            3'b100:  begin e.pbit = 1'b0; e.pen = 1'b1; end
            default: begin e.pbit = 1'b0; e.pen = 1'b0; end
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge with
    // the inputs scrambled to prove the in-flight word is isolated.
    task automatic issue(input logic [7:0] d, input logic [3:0] len,
                         input logic [2:0] mode, input string name);
        int w = 0;
        while (data_ready !== 1'b1 && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w == BOUND) begin
            n_fail++;
            $display("FAIL %s_ready: data_ready got %b want 1 within %0d cycles", name, data_ready, BOUND);
        end
        data_in    = d;
        data_len   = len;
        par_mode   = mode;
        data_valid = 1'b1;
        sb.push_back(model(d, len, mode));
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = ~d;
        data_len   = 4'd2;
        par_mode   = 3'b011;
        n_checks++;
        if (data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_accept: data_ready got %b want 0 after accept", name, data_ready);
        end
    endtask

    // Starts lat0 cycles after the accept edge; waits for parity_valid and
    // compares against the scoreboard head.
    task automatic wait_hold(input string name, input int lat0, output exp_t e);
        int lat = lat0;
        while (parity_valid !== 1'b1 && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        n_checks++;
        if (lat == BOUND) begin
            n_fail++;
            $display("FAIL %s_timeout: parity_valid got %b want 1 within %0d cycles", name, parity_valid, BOUND);
            return;
        end
        if (lat != e.lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat);
        end
        n_checks++;
        if (parity_bit !== e.pbit || parity_en !== e.pen) begin
            n_fail++;
            $display("FAIL %s_result: bit/en got %b%b want %b%b", name, parity_bit, parity_en, e.pbit, e.pen);
        end
    endtask

    // Lingers one cycle in HOLD, pulses frame_done and checks the return
    // to IDLE with the result retained.
    task automatic end_frame(input string name, input exp_t e);
        @(negedge clk);
        n_checks++;
        if (parity_valid !== 1'b1 || parity_bit !== e.pbit || parity_en !== e.pen) begin
            n_fail++;
            $display("FAIL %s_hold: valid/bit/en got %b%b%b want 1%b%b", name,
                     parity_valid, parity_bit, parity_en, e.pbit, e.pen);
        end
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        n_checks++;
        if ({data_ready, parity_valid, parity_bit, parity_en} !== {2'b10, e.pbit, e.pen}) begin
            n_fail++;
            $display("FAIL %s_idle: ready/valid/bit/en got %b%b%b%b want 10%b%b", name,
                     data_ready, parity_valid, parity_bit, parity_en, e.pbit, e.pen);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [3:0] len,
                             input logic [2:0] mode, input string name);
        exp_t e;
        issue(d, len, mode, name);
        wait_hold(name, 0, e);
        end_frame(name, e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({data_ready, parity_valid, parity_bit, parity_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_active: ready/valid/bit/en got %b%b%b%b want 0000",
                     data_ready, parity_valid, parity_bit, parity_en);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({data_ready, parity_valid, parity_bit, parity_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release: ready/valid/bit/en got %b%b%b%b want 1000",
                     data_ready, parity_valid, parity_bit, parity_en);
        end
    endtask

    task automatic test_even_odd();
        run_frame(8'hA5, 4'd8, 3'b001, "even_a5");
        run_frame(8'hA5, 4'd8, 3'b010, "odd_a5");
        run_frame(8'h01, 4'd8, 3'b001, "even_01");
    endtask

    task automatic test_short_frame();
        run_frame(8'hFF, 4'd5,  3'b001, "len5_ff");
        run_frame(8'h07, 4'd3,  3'b001, "len3_clamp");
        run_frame(8'h80, 4'd15, 3'b001, "len15_clamp");
        run_frame(8'h80, 4'd7,  3'b001, "len7_msb_excluded");
        run_frame(8'h40, 4'd7,  3'b010, "len7_odd");
    endtask

    task automatic test_fixed_modes();
        run_frame(8'h5A, 4'd8, 3'b011, "mark");
        run_frame(8'h5A, 4'd8, 3'b100, "space");
        run_frame(8'h5B, 4'd8, 3'b110, "mode110_none");
        run_frame(8'h5B, 4'd8, 3'b000, "mode000_none");
        run_frame(8'h5B, 4'd6, 3'b111, "mode111_none");
    endtask

    task automatic test_frame_done_ignored();
        exp_t e;
        // frame_done in IDLE must not disturb anything.
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        n_checks++;
        if (data_ready !== 1'b1 || parity_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fd_idle: ready/valid got %b%b want 10", data_ready, parity_valid);
        end
        // frame_done in CALC must not cut the computation short.
        issue(8'h3C, 4'd8, 3'b010, "fd_calc");
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        wait_hold("fd_calc", 1, e);
        end_frame("fd_calc", e);
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        acc_times.delete();
        data_in    = 8'hC3;
        data_len   = 4'd8;
        par_mode   = 3'b001;
        data_valid = 1'b1;
        sb.push_back(model(8'hC3, 4'd8, 3'b001));
        @(negedge clk);
        wait_hold("b2b_first", 0, e1);
        n_checks++;
        if (acc_times.size() != 1) begin
            n_fail++;
            $display("FAIL b2b_single_accept: accepts got %0d want 1", acc_times.size());
        end
        // Next word offered while frame_done closes the first frame.
        data_in  = 8'h01;
        par_mode = 3'b010;
        sb.push_back(model(8'h01, 4'd8, 3'b010));
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        n_checks++;
        if (data_ready !== 1'b1 || parity_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_only: ready/valid got %b%b want 10", data_ready, parity_valid);
        end
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 8'hFF;
        n_checks++;
        if (acc_times.size() != 2 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_accept: accepts/ready got %0d/%b want 2/0", acc_times.size(), data_ready);
        end else begin
            n_checks++;
            if (acc_times[1] - acc_times[0] != 10) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d want 10", acc_times[1] - acc_times[0]);
            end
        end
        wait_hold("b2b_second", 0, e2);
        end_frame("b2b_second", e2);
    endtask

    task automatic test_reset_mid_calc();
        bit seen_valid = 1'b0;
        issue(8'hA5, 4'd8, 3'b010, "rst_calc");
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({data_ready, parity_valid, parity_bit, parity_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_calc_active: ready/valid/bit/en got %b%b%b%b want 0000",
                     data_ready, parity_valid, parity_bit, parity_en);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({data_ready, parity_valid, parity_bit, parity_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_calc_release: ready/valid/bit/en got %b%b%b%b want 1000",
                     data_ready, parity_valid, parity_bit, parity_en);
        end
        for (int i = 0; i < 12; i++) begin
            if (parity_valid !== 1'b0) seen_valid = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen_valid) begin
            n_fail++;
            $display("FAIL rst_calc_no_pulse: parity_valid got 1 want 0 for aborted word");
        end
        run_frame(8'hE7, 4'd8, 3'b010, "after_rst");
    endtask

`ifdef UART_PARITY_CHECK_EN
    task automatic test_parity_check();
        exp_t e;
        issue(8'hA5, 4'd8, 3'b001, "chk_bad");
        wait_hold("chk_bad", 0, e);
        chk_bit    = 1'b1;
        chk_strobe = 1'b1;
        @(negedge clk);
        chk_strobe = 1'b0;
        n_checks++;
        if (parity_err !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_mismatch: parity_err got %b want 1", parity_err);
        end
        end_frame("chk_bad", e);
        n_checks++;
        if (parity_err !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_sticky: parity_err got %b want 1", parity_err);
        end
        issue(8'hA5, 4'd8, 3'b001, "chk_good");
        n_checks++;
        if (parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_clear_on_accept: parity_err got %b want 0", parity_err);
        end
        wait_hold("chk_good", 0, e);
        chk_bit    = 1'b0;
        chk_strobe = 1'b1;
        @(negedge clk);
        chk_strobe = 1'b0;
        n_checks++;
        if (parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_match: parity_err got %b want 0", parity_err);
        end
        end_frame("chk_good", e);
        // Strobe outside HOLD is ignored.
        chk_bit    = 1'b1;
        chk_strobe = 1'b1;
        @(negedge clk);
        chk_strobe = 1'b0;
        n_checks++;
        if (parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_idle_ignored: parity_err got %b want 0", parity_err);
        end
        // Strobe with parity disabled is ignored.
        issue(8'hA5, 4'd8, 3'b000, "chk_none");
        wait_hold("chk_none", 0, e);
        chk_strobe = 1'b1;
        @(negedge clk);
        chk_strobe = 1'b0;
        n_checks++;
        if (parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_none_ignored: parity_err got %b want 0", parity_err);
        end
        end_frame("chk_none", e);
    endtask
`endif

    initial begin
        test_reset();
        test_even_odd();
        test_short_frame();
        test_fixed_modes();
        test_frame_done_ignored();
        test_back_to_back();
        test_reset_mid_calc();
`ifdef UART_PARITY_CHECK_EN
        test_parity_check();
`endif
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: entries left %0d want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
